// File: rtl/pdm_cic_decim.sv
// -----------------------------------------------------------------------------
// pdm_cic_decim
//   PDM microphone front end: generates the microphone bit clock, captures the
//   PDM bitstream once per bit-clock period, and decimates it to signed PCM with
//   a 4th-order CIC (4 integrators at the bit rate, decimate by DECIM, 4 combs
//   at the sample rate), followed by scaling and saturation to DATA_WIDTH.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset (wins over en)
//   en           in   run enable; low holds the block idle/cleared (sample holds)
//   pdm_clk      out  microphone bit clock, period 2*PDM_DIV clk cycles
//   pdm_data     in   microphone PDM bitstream
//   sample       out  signed PCM sample, DATA_WIDTH bits
//   sample_valid out  one-cycle strobe when sample updates
// -----------------------------------------------------------------------------
module pdm_cic_decim #(
    parameter int CLK_FREQ    = 44000000,
    parameter int SAMPLE_RATE = 34375,
    parameter int DECIM       = 64,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  pdm_clk,
    input  logic                  pdm_data,
    output logic [DATA_WIDTH-1:0] sample,
    output logic                  sample_valid
);

    localparam int PDM_DIV = CLK_FREQ / (2 * SAMPLE_RATE * DECIM);
    localparam int DIV_W   = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
    localparam int LOG2D   = $clog2(DECIM);
    localparam int W       = 2 + 4 * LOG2D;
    localparam int SHIFT   = 4 * LOG2D + 1 - DATA_WIDTH;
    localparam int ORDER   = 4;
    localparam int SETTLE  = 4;

    localparam logic signed [W-1:0] SAT_MAX = W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN = -W'(1 << (DATA_WIDTH - 1));

    // Bit-clock divider and capture
    logic [DIV_W-1:0] div_q, div_d;
    logic             pdm_clk_q, pdm_clk_d;
    logic             capture;

    // Frame / settle bookkeeping
    logic [LOG2D-1:0] frame_q, frame_d;
    logic             frame_close;
    logic [2:0]       settle_q, settle_d;

    // CIC state
    logic signed [W-1:0] integ_q [ORDER];
    logic signed [W-1:0] integ_d [ORDER];
    logic signed [W-1:0] dly_q   [ORDER];
    logic signed [W-1:0] dly_d   [ORDER];
    logic signed [W-1:0] comb_out_q, comb_out_d;
    logic signed [W-1:0] x;
    logic signed [W-1:0] acc;
    logic signed [W-1:0] shifted;

    // comb_go: frame closed last cycle, run the combs.
    // vld_pipe[0]: closed frame is past settling; vld_pipe[1]: comb result ready.
    logic       comb_go_q, comb_go_d;
    logic [1:0] vld_pipe_q, vld_pipe_d;

    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;

    always_comb begin
        div_d       = div_q;
        pdm_clk_d   = pdm_clk_q;
        capture     = 1'b0;
        frame_d     = frame_q;
        frame_close = 1'b0;
        settle_d    = settle_q;
        comb_out_d  = comb_out_q;
        x           = pdm_data ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
        acc         = '0;
        shifted     = '0;
        sample_d    = sample_q;
        for (int i = 0; i < ORDER; i++) begin
            integ_d[i] = integ_q[i];
            dly_d[i]   = dly_q[i];
        end

        // Toggle every PDM_DIV cycles; the 0->1 toggle is the capture edge.
        if (div_q == DIV_W'(PDM_DIV - 1)) begin
            div_d     = '0;
            pdm_clk_d = !pdm_clk_q;
            capture   = !pdm_clk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Integrators chained within one capture so the cascade adds no
        // extra bit-rate delay.
        if (capture) begin
            acc = x;
            for (int i = 0; i < ORDER; i++) begin
                integ_d[i] = integ_q[i] + acc;
                acc        = integ_d[i];
            end
            if (frame_q == LOG2D'(DECIM - 1)) begin
                frame_d     = '0;
                frame_close = 1'b1;
            end else begin
                frame_d = frame_q + LOG2D'(1);
            end
        end

        if (frame_close && settle_q != 3'(SETTLE))
            settle_d = settle_q + 3'd1;

        comb_go_d     = frame_close;
        vld_pipe_d[0] = frame_close && (settle_q == 3'(SETTLE));
        vld_pipe_d[1] = vld_pipe_q[0];

        // Combs run on the cycle after the close; the last integrator is
        // stable then because captures are at least 2 cycles apart.
        if (comb_go_q) begin
            acc = integ_q[ORDER-1];
            for (int i = 0; i < ORDER; i++) begin
                dly_d[i] = acc;
                acc      = acc - dly_q[i];
            end
            comb_out_d = acc;
        end

        shifted = comb_out_q >>> SHIFT;
        if (vld_pipe_q[1]) begin
            if (shifted > SAT_MAX)
                sample_d = SAT_MAX[DATA_WIDTH-1:0];
            else if (shifted < SAT_MIN)
                sample_d = SAT_MIN[DATA_WIDTH-1:0];
            else
                sample_d = shifted[DATA_WIDTH-1:0];
        end
        sample_valid_d = vld_pipe_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_q          <= '0;
            pdm_clk_q      <= 1'b0;
            frame_q        <= '0;
            settle_q       <= '0;
            comb_out_q     <= '0;
            comb_go_q      <= 1'b0;
            vld_pipe_q     <= '0;   // drops any sample still in the comb pipe
            sample_valid_q <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= '0;
                dly_q[i]   <= '0;
            end
            if (rst)
                sample_q <= '0;     // en low alone keeps the last sample
        end else begin
            div_q          <= div_d;
            pdm_clk_q      <= pdm_clk_d;
            frame_q        <= frame_d;
            settle_q       <= settle_d;
            comb_out_q     <= comb_out_d;
            comb_go_q      <= comb_go_d;
            vld_pipe_q     <= vld_pipe_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            for (int i = 0; i < ORDER; i++) begin
                integ_q[i] <= integ_d[i];
                dly_q[i]   <= dly_d[i];
            end
        end
    end

    assign pdm_clk      = pdm_clk_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Randomized bench for pdm_cic_decim. Reference: the CIC is modelled as its
// equivalent FIR (boxcar of length DECIM convolved with itself 4 times) applied
// to the list of captured bits, then scaled and saturated.
module tb_pdm_cic_decim;
    localparam int CLK_FREQ    = 44000000;
    localparam int SAMPLE_RATE = 34375;
    localparam int DECIM       = 64;
    localparam int DW          = 16;
    localparam int PDIV        = CLK_FREQ / (2 * SAMPLE_RATE * DECIM);
    localparam int NTAP        = 4 * (DECIM - 1) + 1;
    localparam int FRAME       = 2 * PDIV * DECIM;
    localparam int SHIFT       = 4 * $clog2(DECIM) + 1 - DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          pdm_data = 1'b0;
    logic          pdm_clk;
    logic [DW-1:0] sample;
    logic          sample_valid;

    always #5 clk = ~clk;

    pdm_cic_decim #(
        .CLK_FREQ(CLK_FREQ), .SAMPLE_RATE(SAMPLE_RATE),
        .DECIM(DECIM), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pdm_clk(pdm_clk),
        .pdm_data(pdm_data), .sample(sample), .sample_valid(sample_valid)
    );

    int     checks = 0;
    int     errors = 0;
    longint h [NTAP];
    bit     bits [$];
    int     t = 0;          // clk edges since enable (0 = idle)
    int     cap_n = 0;      // captures since enable
    int     pend_t = -1;    // edge at which the next strobe is due
    longint pend_v = 0;
    longint exp_s = 0;
    int     last_v = -1;
    int     last_close = -10;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic bit pat_bit(input int p, input int n);
        case (p)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (n % 2) == 0;
            3:       return (n % 4) != 3;
            default: return 1'($urandom_range(1, 0));
        endcase
    endfunction

    function automatic longint ref_out();
        longint y = 0;
        int n = bits.size() - 1;
        for (int j = 0; j < NTAP; j++)
            if (n - j >= 0) y += h[j] * (bits[n-j] ? 1 : -1);
        y = y >>> SHIFT;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    // One clk cycle: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit e, input bit r, input int p);
        int tn;
        bit cap;
        bit b;
        tn  = (e && !r) ? t + 1 : 0;
        cap = (tn >= PDIV) && (((tn - PDIV) % (2 * PDIV)) == 0);
        b   = cap ? pat_bit(p, cap_n) : 1'($urandom_range(1, 0));
        en = e; rst = r; pdm_data = b;
        @(posedge clk); #1;
        t = tn;
        if (tn == 0) begin
            cap_n = 0; bits.delete(); pend_t = -1; last_v = -1;
            if (r) exp_s = 0;
        end else if (cap) begin
            bits.push_back(b);
            if (cap_n % DECIM == DECIM - 1) begin
                last_close = t;
                if (cap_n / DECIM >= 4) begin
                    pend_t = t + 2;
                    pend_v = ref_out();
                end
            end
            cap_n++;
        end
        chk("pdm_clk", pdm_clk, (tn == 0) ? 0 : (tn / PDIV) % 2);
        chk("sample_valid", sample_valid, (t == pend_t) ? 1 : 0);
        if (t == pend_t) begin
            exp_s  = pend_v;
            pend_t = -1;
            if (last_v >= 0) chk("strobe_spacing", t - last_v, FRAME);
            last_v = t;
        end
        chk("sample", $signed(sample), exp_s);
    endtask

    initial begin
        longint tmp [NTAP];
        int len;
        int n;
        // FIR taps of (1 + z^-1 + ... + z^-(DECIM-1))^4
        foreach (h[i]) h[i] = 0;
        h[0] = 1;
        len  = 1;
        repeat (4) begin
            foreach (tmp[i]) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int k = 0; k < DECIM; k++) tmp[i+k] += h[i];
            h   = tmp;
            len += DECIM - 1;
        end

        repeat (3) step(1'b1, 1'b1, 0);       // rst wins over en
        chk("rst_pdm_clk", pdm_clk, 0);
        chk("rst_sample", $signed(sample), 0);
        chk("rst_valid", sample_valid, 0);

        repeat (7 * FRAME) step(1'b1, 1'b0, 0);
        chk("ones_full_scale", $signed(sample), 32767);
        repeat (4) step(1'b0, 1'b0, 0);
        chk("en_low_hold", $signed(sample), 32767);
        chk("en_low_pdm_clk", pdm_clk, 0);

        repeat (7 * FRAME) step(1'b1, 1'b0, 1);
        chk("zeros_neg_full", $signed(sample), -32768);
        repeat (3) step(1'b0, 1'b0, 1);

        repeat (7 * FRAME) step(1'b1, 1'b0, 2);
        chk("alternating_zero", $signed(sample), 0);
        repeat (3) step(1'b0, 1'b0, 2);

        repeat (7 * FRAME) step(1'b1, 1'b0, 3);
        chk("pattern_1110", $signed(sample), 16384);
        repeat (3) step(1'b0, 1'b0, 3);

        // Random data, then a one-cycle reset in the middle of a frame
        repeat (6 * FRAME + FRAME / 2) step(1'b1, 1'b0, 4);
        step(1'b1, 1'b1, 4);
        chk("midrst_pdm_clk", pdm_clk, 0);
        chk("midrst_sample", $signed(sample), 0);
        chk("midrst_valid", sample_valid, 0);
        repeat (7 * FRAME) step(1'b1, 1'b0, 4);

        // Drop en for one cycle right after a frame-closing capture edge
        n = 0;
        while (last_close != t && n < 3 * FRAME) begin
            step(1'b1, 1'b0, 4);
            n++;
        end
        chk("close_found", (last_close == t) ? 1 : 0, 1);
        step(1'b0, 1'b0, 4);
        chk("drop_no_strobe", sample_valid, 0);
        chk("drop_pdm_clk", pdm_clk, 0);
        repeat (6 * FRAME) step(1'b1, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
